// File: rtl/conn_table_lookup_arbiter_pkg.sv
// Shared types and sizes for the connection-config table arbiter.
// Table index is {port_id, vlan}; responses are tagged with their owner.
package conn_tbl_pkg;

    localparam int NUM_PORTS   = 8;
    localparam int PORT_W      = $clog2(NUM_PORTS);
    localparam int VLAN_W      = 12;
    localparam int TBL_ADDR_W  = PORT_W + VLAN_W;
    localparam int DATA_SIZE   = 32;
    localparam int MAX_CFG_RUN = 4;
    localparam int CFG_RUN_W   = $clog2(MAX_CFG_RUN + 1);

    typedef struct packed {
        logic [PORT_W-1:0] port_id;
        logic [VLAN_W-1:0] vlan;
    } conn_addr_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } arb_state_e;

    typedef struct packed {
        logic              valid;
        logic              is_cfg;
        logic [PORT_W-1:0] owner;
    } rsp_tag_t;

endpackage

// File: rtl/conn_table_lookup_arbiter_rr.sv
// Round-robin picker: first request at or after the pointer, upward.
// The pointer moves past the winner only when the grant is enabled.
module rr_arbiter_nports
    import conn_tbl_pkg::*;
#(
    parameter int NUM_PORTS = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic                         en_i,
    output logic [NUM_PORTS-1:0]         gnt_o,
    output logic [$clog2(NUM_PORTS)-1:0] idx_o,
    output logic                         found_o
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] pick;
    logic             found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && req_i[(int'(ptr_q) + k) % NUM_PORTS]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(ptr_q) + k) % NUM_PORTS);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        if (en_i && found) begin
            gnt_o[pick] = 1'b1;
            ptr_d = (int'(pick) == NUM_PORTS - 1) ? '0 : pick + 1'b1;
        end
    end

    assign idx_o   = pick;
    assign found_o = found;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/conn_table_lookup_arbiter.sv
// Shares the single-port connection table between per-port lookups and the
// config path: zero-fill after reset, guarded cfg priority, tagged responses.
module conn_table_lookup_arbiter
    import conn_tbl_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        lk_valid,
    input  logic [NUM_PORTS*VLAN_W-1:0] lk_vlan,
    output logic [NUM_PORTS-1:0]        lk_ready,
    output logic [NUM_PORTS-1:0]        lk_rvalid,
    output logic [DATA_SIZE-1:0]        lk_rdata,
    input  logic                        cfg_valid,
    input  logic                        cfg_we,
    input  logic [TBL_ADDR_W-1:0]       cfg_addr,
    input  logic [DATA_SIZE-1:0]        cfg_wdata,
    output logic                        cfg_ready,
    output logic                        cfg_rvalid,
    output logic [DATA_SIZE-1:0]        cfg_rdata,
    output logic                        init_done,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [TBL_ADDR_W-1:0]       mem_addr,
    output logic [DATA_SIZE-1:0]        mem_wdata,
    input  logic [DATA_SIZE-1:0]        mem_rdata
);

    arb_state_e            state_q, state_d;
    logic [TBL_ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    logic [CFG_RUN_W-1:0]  run_q, run_d;
    rsp_tag_t              tag0_q, tag0_d, tag1_q;
    logic [DATA_SIZE-1:0]  rdata_q;

    logic                  running;
    logic                  any_lk;
    logic                  cfg_win;
    logic                  lk_en;
    logic [NUM_PORTS-1:0]  lk_gnt;
    logic [PORT_W-1:0]     lk_idx;
    logic                  lk_found;
    conn_addr_t            lk_addr;

    assign running = (state_q == ST_RUN);
    assign any_lk  = |lk_valid;
    assign cfg_win = cfg_valid && (!any_lk || run_q < CFG_RUN_W'(MAX_CFG_RUN));
    assign lk_en   = running && !cfg_win;

    rr_arbiter_nports #(
        .NUM_PORTS(NUM_PORTS)
    ) u_rr (
        .clk_i  (clk),
        .reset_i(reset),
        .req_i  (lk_valid),
        .en_i   (lk_en),
        .gnt_o  (lk_gnt),
        .idx_o  (lk_idx),
        .found_o(lk_found)
    );

    assign lk_ready  = lk_gnt;
    assign cfg_ready = running && cfg_win;

    assign lk_addr.port_id = lk_idx;
    assign lk_addr.vlan    = lk_vlan[lk_idx*VLAN_W +: VLAN_W];

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        run_d       = run_q;
        tag0_d      = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        unique case (state_q)
            ST_INIT: begin
                // keep the RAM quiet while reset is still held
                mem_en     = !reset;
                mem_we     = !reset;
                mem_addr   = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (&init_cnt_q) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (cfg_ready) begin
                    mem_en        = 1'b1;
                    mem_we        = cfg_we;
                    mem_addr      = cfg_addr;
                    mem_wdata     = cfg_wdata;
                    tag0_d.valid  = !cfg_we;
                    tag0_d.is_cfg = 1'b1;
                end else if (lk_found) begin
                    mem_en       = 1'b1;
                    mem_addr     = lk_addr;
                    tag0_d.valid = 1'b1;
                    tag0_d.owner = lk_idx;
                end
                if (cfg_ready && any_lk) begin
                    if (run_q != CFG_RUN_W'(MAX_CFG_RUN)) begin
                        run_d = run_q + 1'b1;
                    end
                end else begin
                    run_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            run_q       <= '0;
            tag0_q      <= '0;
            tag1_q      <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            run_q       <= run_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag0_q;
            if (tag0_q.valid) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign init_done  = init_done_q;
    assign lk_rvalid  = (tag1_q.valid && !tag1_q.is_cfg)
                      ? (NUM_PORTS'(1) << tag1_q.owner) : '0;
    assign cfg_rvalid = tag1_q.valid && tag1_q.is_cfg;
    assign lk_rdata   = rdata_q;
    assign cfg_rdata  = rdata_q;

endmodule

// File: tb/tb_conn_table_lookup_arbiter.sv
// Randomized bench with a reference model of grants and table contents;
// expected responses go into a queue that a separate monitor drains.
module tb_conn_table_lookup_arbiter;

    localparam int NP = 8;
    localparam int VW = 12;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     lk_valid;
    logic [NP*VW-1:0]  lk_vlan;
    logic [NP-1:0]     lk_ready;
    logic [NP-1:0]     lk_rvalid;
    logic [DW-1:0]     lk_rdata;
    logic              cfg_valid;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [DW-1:0]     cfg_wdata;
    logic              cfg_ready;
    logic              cfg_rvalid;
    logic [DW-1:0]     cfg_rdata;
    logic              init_done;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    conn_table_lookup_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .lk_valid  (lk_valid),
        .lk_vlan   (lk_vlan),
        .lk_ready  (lk_ready),
        .lk_rvalid (lk_rvalid),
        .lk_rdata  (lk_rdata),
        .cfg_valid (cfg_valid),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready),
        .cfg_rvalid(cfg_rvalid),
        .cfg_rdata (cfg_rdata),
        .init_done (init_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write-first single-port table RAM, one cycle read latency
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            ram_q <= mem_we ? mem_wdata : ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    typedef struct {
        bit          is_cfg;
        int          owner;
        logic [31:0] data;
        longint      due;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    logic [31:0] ref_mem [DEPTH];
    int          icnt = 0;
    int          ptr = 0;
    int          rcnt = 0;
    int          init_bad = 0;
    int          init_writes = 0;
    bit          zeroed = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // reference model: init sequence, grant choice, table shadow
    always @(negedge clk) begin
        logic [NP-1:0] elk;
        bit            ecfg;
        bit            any;
        int            g;
        logic [AW-1:0] ea;
        exp_t          e;
        if (reset) begin
            sbq.delete();
            icnt = 0;
            ptr  = 0;
            rcnt = 0;
            if (!zeroed) begin
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
                zeroed = 1;
            end
            chk("rst_outputs",
                {lk_rvalid, cfg_rvalid, init_done, lk_ready, cfg_ready, mem_en}, 0);
        end else if (icnt < DEPTH) begin
            zeroed = 0;
            if (mem_en && mem_we && mem_wdata == 0 && int'(mem_addr) == icnt
                && !init_done && lk_ready == 0 && !cfg_ready)
                init_writes++;
            else
                init_bad++;
            icnt++;
        end else begin
            if (icnt == DEPTH) begin
                chk("init_done_rise", {63'h0, init_done}, 1);
                icnt++;
            end
            elk  = '0;
            ecfg = 0;
            ea   = '0;
            any  = |lk_valid;
            if (cfg_valid && (!any || rcnt < 4)) begin
                ecfg = 1;
                ea   = cfg_addr;
                if (cfg_we) begin
                    ref_mem[cfg_addr] = cfg_wdata;
                end else begin
                    e.is_cfg = 1; e.owner = 0;
                    e.data = ref_mem[cfg_addr]; e.due = cyc + 2;
                    sbq.push_back(e);
                end
                rcnt = any ? ((rcnt < 4) ? rcnt + 1 : 4) : 0;
            end else if (any) begin
                g = -1;
                for (int k = 0; k < NP; k++)
                    if (g < 0 && lk_valid[(ptr + k) % NP]) g = (ptr + k) % NP;
                elk[g] = 1'b1;
                ea = {g[2:0], lk_vlan[g*VW +: VW]};
                e.is_cfg = 0; e.owner = g;
                e.data = ref_mem[ea]; e.due = cyc + 2;
                sbq.push_back(e);
                ptr  = (g + 1) % NP;
                rcnt = 0;
            end else begin
                rcnt = 0;
            end
            chk("lk_ready", lk_ready, elk);
            chk("cfg_ready", {63'h0, cfg_ready}, {63'h0, ecfg});
            if (ecfg || elk != 0)
                chk("mem_access", {mem_en, mem_we, mem_addr},
                    {1'b1, ecfg && cfg_we, ea});
            if (ecfg && cfg_we)
                chk("mem_wdata", mem_wdata, cfg_wdata);
        end
    end

    // response monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (lk_rvalid != 0 || cfg_rvalid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", {lk_rvalid, cfg_rvalid}, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_cycle", cyc, e.due);
                    if (e.is_cfg) begin
                        chk("cfg_rsp", {lk_rvalid, cfg_rvalid}, 9'b1);
                        chk("cfg_rdata", cfg_rdata, e.data);
                    end else begin
                        chk("lk_rsp", {lk_rvalid, cfg_rvalid},
                            {8'(1 << e.owner), 1'b0});
                        chk("lk_rdata", lk_rdata, e.data);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk("rsp_missing", {lk_rvalid, cfg_rvalid},
                    e.is_cfg ? 9'b1 : {8'(1 << e.owner), 1'b0});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        lk_valid  = '0;
        cfg_valid = 1'b0;
        cfg_we    = 1'b0;
    endtask

    task automatic rand_vlans(int lim);
        for (int p = 0; p < NP; p++) lk_vlan[p*VW +: VW] = VW'($urandom_range(lim));
    endtask

    task automatic random_run(int n);
        for (int i = 0; i < n; i++) begin
            lk_valid  = NP'($urandom & $urandom);
            rand_vlans(7);
            cfg_valid = ($urandom % 3) == 0;
            cfg_we    = $urandom % 2;
            cfg_addr  = {3'($urandom), 12'($urandom_range(7))};
            cfg_wdata = $urandom;
            step();
        end
        idle_in();
    endtask

    initial begin
        reset     = 1'b0;
        lk_valid  = '0;
        lk_vlan   = '0;
        cfg_valid = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        #1 reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (DEPTH + 2) step();

        cfg_valid = 1'b1; cfg_we = 1'b1;
        cfg_addr = 15'h3005; cfg_wdata = 32'hDEADBEEF;
        step();
        idle_in();
        lk_valid = 8'b0000_1000;
        lk_vlan[3*VW +: VW] = 12'h005;
        step();
        idle_in();
        repeat (4) step();

        lk_valid = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            rand_vlans(7);
            step();
        end
        idle_in();
        repeat (4) step();

        cfg_valid = 1'b1; cfg_we = 1'b0; lk_valid = 8'h01;
        for (int i = 0; i < 20; i++) begin
            cfg_addr = {3'($urandom), 12'($urandom_range(7))};
            step();
        end
        idle_in();
        repeat (4) step();

        cfg_valid = 1'b1; cfg_we = 1'b1;
        cfg_addr = 15'h0123; cfg_wdata = 32'hA5A5A5A5;
        step();
        cfg_we = 1'b0;
        step();
        idle_in();
        repeat (4) step();

        random_run(3000);
        repeat (5) step();

        lk_valid = 8'h06;
        step();
        step();
        idle_in();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (DEPTH + 2) step();
        random_run(200);
        repeat (6) step();

        chk("init_writes", init_writes, 2 * DEPTH);
        chk("init_bad", init_bad, 0);
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
